// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 master bridge: FSM states,
// pprot bit meanings and the captured request record.
package apb4_master_pkg;

    localparam int APB_MAX_ADDR_W = 32;
    localparam int APB_MAX_DATA_W = 32;
    localparam int APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_MAX_ADDR_W-1:0] addr;
        logic                      write;
        logic [APB_MAX_DATA_W-1:0] wdata;
        logic [APB_MAX_STRB_W-1:0] strb;
        logic [2:0]                prot;
    } apb4_req_t;

endpackage

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: valid/ready request in, one SETUP/ACCESS
// transfer on APB, valid/ready response out, with an optional access timeout.
module apb4_master_bridge
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e              state_r;
    apb_state_e              state_next_s;
    apb4_req_t               req_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    timeout_hit_s;
    logic                    psel_r;
    logic                    penable_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;

    // Next-state and timeout-counter logic
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        timeout_hit_s = 1'b0;
        // Saturating increment: the counter can never wrap back to zero
        cnt_inc_s     = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_next_s = ST_ACCESS;
                cnt_next_s   = '0;
            end
            ST_ACCESS: begin
                cnt_next_s = cnt_inc_s;
                if (pready_i) begin
                    state_next_s = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_inc_s >= CNT_W'(TIMEOUT))) begin
                    timeout_hit_s = 1'b1;
                    state_next_s  = ST_RESP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State and timeout counter registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered handshake/APB controls, decoded from the upcoming state
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            req_ready_r <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            psel_r      <= (state_next_s == ST_SETUP) || (state_next_s == ST_ACCESS);
            penable_r   <= (state_next_s == ST_ACCESS);
            rsp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Request capture; strobes are zeroed for reads so pstrb stays 0 on the bus
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            req_r <= '0;
        end else if ((state_r == ST_IDLE) && req_valid_i) begin
            req_r.addr  <= APB_MAX_ADDR_W'(req_addr_i);
            req_r.write <= req_write_i;
            req_r.wdata <= APB_MAX_DATA_W'(req_wdata_i);
            req_r.strb  <= req_write_i ? APB_MAX_STRB_W'(req_strb_i) : {APB_MAX_STRB_W{1'b0}};
            req_r.prot  <= req_prot_i;
        end
    end

    // Response capture: pready wins over timeout, flags clear on handshake
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if ((state_r == ST_ACCESS) && pready_i) begin
            rsp_rdata_r   <= req_r.write ? {DATA_WIDTH{1'b0}} : prdata_i;
            rsp_err_r     <= pslverr_i;
            rsp_timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else if ((state_r == ST_RESP) && rsp_ready_i) begin
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end
    end

    assign req_ready_o   = req_ready_r;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign paddr_o       = req_r.addr[ADDR_WIDTH-1:0];
    assign pwrite_o      = req_r.write;
    assign pwdata_o      = req_r.wdata[DATA_WIDTH-1:0];
    assign pstrb_o       = req_r.strb[STRB_WIDTH-1:0];
    assign pprot_o       = req_r.prot;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed vector table, random
// transfers against a transfer-level model, and reset/backpressure sequences.
`timescale 1ns/1ps
module tb_apb4_master_bridge;

    localparam int TMO = 4;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic [2:0]  pprot_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int checks   = 0;
    int failures = 0;

    // Responder configuration and its wait-state counter
    int          wait_cfg = 0;
    logic        hang_cfg = 1'b0;
    logic        err_cfg  = 1'b0;
    logic [31:0] rd_cfg   = 32'h0;
    int          acc_cnt;

    apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn)                 acc_cnt <= 0;
        else if (psel_o && penable_o) acc_cnt <= acc_cnt + 1;
        else                          acc_cnt <= 0;
    end

    assign pready_i  = psel_o && penable_o && !hang_cfg && (acc_cnt == wait_cfg);
    assign prdata_i  = rd_cfg;
    assign pslverr_i = pready_i && err_cfg;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;      // wait states before pready; large value = hung responder
        logic        slverr;
        logic [31:0] prdata;
        int          rsp_delay;  // cycles rsp_ready is held low
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;    // cycles from accept edge to first rsp_valid
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transfer-level reference: responder answers on ACCESS cycle waits+1,
    // the bridge gives up after TMO ACCESS cycles; pready wins on a tie.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   acc;
        if (v.waits + 1 <= TMO) begin
            acc         = v.waits + 1;
            r.exp_err   = v.slverr;
            r.exp_to    = 1'b0;
            r.exp_rdata = v.write ? 32'h0 : v.prdata;
        end else begin
            acc         = TMO;
            r.exp_err   = 1'b1;
            r.exp_to    = 1'b1;
            r.exp_rdata = 32'h0;
        end
        r.exp_lat = 2 + acc;
        return r;
    endfunction

    task automatic run_xfer(input string tag, input vec_t v);
        int   n;
        int   lat;
        logic bus_ok;
        logic hold_ok;
        wait_cfg    = v.waits;
        err_cfg     = v.slverr;
        rd_cfg      = v.prdata;
        req_valid_i = 1'b1;
        req_addr_i  = v.addr;
        req_write_i = v.write;
        req_wdata_i = v.wdata;
        req_strb_i  = v.strb;
        req_prot_i  = v.prot;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge hclk);
            n++;
        end
        check({tag, " req_ready"}, {63'd0, req_ready_o}, 64'd1);
        @(posedge hclk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_strb_i  = 4'($urandom);
        req_write_i = 1'($urandom);
        req_prot_i  = 3'($urandom);
        lat    = 0;
        bus_ok = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge hclk);
            if (rsp_valid_o) begin
                lat = k;
            end else if (psel_o !== 1'b1 || penable_o !== (k >= 2) || paddr_o !== v.addr ||
                         pwrite_o !== v.write || pstrb_o !== (v.write ? v.strb : 4'h0) ||
                         pprot_o !== v.prot || (v.write && pwdata_o !== v.wdata)) begin
                bus_ok = 1'b0;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " apb_phases"}, {63'd0, bus_ok}, 64'd1);
        check({tag, " bus_idle_in_resp"}, {62'd0, psel_o, penable_o}, 64'd0);
        check({tag, " rdata"}, {32'd0, rsp_rdata_o}, {32'd0, v.exp_rdata});
        check({tag, " err_timeout"}, {62'd0, rsp_err_o, rsp_timeout_o}, {62'd0, v.exp_err, v.exp_to});
        hold_ok = 1'b1;
        for (int i = 0; i < v.rsp_delay; i++) begin
            @(negedge hclk);
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== v.exp_rdata || rsp_err_o !== v.exp_err ||
                rsp_timeout_o !== v.exp_to || req_ready_o !== 1'b0 || psel_o !== 1'b0)
                hold_ok = 1'b0;
        end
        check({tag, " rsp_hold"}, {63'd0, hold_ok}, 64'd1);
        rsp_ready_i = 1'b1;
        @(posedge hclk);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge hclk);
        check({tag, " back_to_idle"}, {61'd0, rsp_valid_o, req_ready_o, psel_o}, 64'b010);
    endtask

    initial begin
        vec_t v;
        logic quiet_ok;
        hresetn     = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = 32'h0;
        req_write_i = 1'b0;
        req_wdata_i = 32'h0;
        req_strb_i  = 4'h0;
        req_prot_i  = 3'h0;
        rsp_ready_i = 1'b0;

        //           wr    addr          wdata         strb  prot    waits slverr prdata        dly  exp_rdata     err   to    lat
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0,   1'b0, 32'h0,         0, 32'h0,         1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h1111_2222, 4'hF, 3'b001, 2,   1'b0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b1, 32'h0000_000C, 32'h0000_A5A5, 4'h3, 3'b010, 1,   1'b1, 32'hFFFF_FFFF, 0, 32'h0,         1'b1, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3'b000, 100, 1'b0, 32'hCAFE_0000, 0, 32'h0,         1'b1, 1'b1, 6};
        vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 3'b100, 0,   1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 3};
        vecs[5] = '{1'b1, 32'h0000_0018, 32'h0102_0304, 4'h9, 3'b011, 0,   1'b0, 32'h0,         5, 32'h0,         1'b0, 1'b0, 3};
        vecs[6] = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 3'b000, 3,   1'b0, 32'h5555_AAAA, 0, 32'h5555_AAAA, 1'b0, 1'b0, 6};
        vecs[7] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 3'b000, 3,   1'b1, 32'h0000_0077, 2, 32'h0000_0077, 1'b1, 1'b0, 6};

        #3;
        check("reset_outputs",
              {rsp_rdata_o, paddr_o, req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
               psel_o, penable_o, pwrite_o, pprot_o},
              64'd0);
        check("reset_pbus", {pwdata_o, pstrb_o}, 64'd0);
        #19;
        hresetn = 1'b1;
        @(negedge hclk);
        check("ready_after_reset", {62'd0, req_ready_o, psel_o}, 64'b10);

        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted in the middle of ACCESS
        hang_cfg = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_0040;
        req_write_i = 1'b1;
        for (int n = 0; n < 20 && !(psel_o && penable_o); n++) @(negedge hclk);
        req_valid_i = 1'b0;
        check("mid_reset_in_access", {62'd0, psel_o, penable_o}, 64'b11);
        #2;
        hresetn = 1'b0;
        #1;
        check("mid_reset_async_drop", {61'd0, psel_o, penable_o, rsp_valid_o}, 64'd0);
        repeat (2) @(negedge hclk);
        hresetn  = 1'b1;
        hang_cfg = 1'b0;
        quiet_ok = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge hclk);
            if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) quiet_ok = 1'b0;
        end
        check("no_rsp_after_reset", {63'd0, quiet_ok}, 64'd1);
        run_xfer("post_reset", vecs[1]);

        // Random transfers against the transfer-level model
        for (int i = 0; i < 30; i++) begin
            v.write     = 1'($urandom);
            v.addr      = $urandom & 32'hFFFF_FFFC;
            v.wdata     = $urandom;
            v.strb      = 4'($urandom);
            v.prot      = 3'($urandom);
            v.waits     = int'($urandom_range(0, 6));
            v.slverr    = 1'($urandom_range(0, 3) == 0);
            v.prdata    = $urandom;
            v.rsp_delay = int'($urandom_range(0, 3));
            v = model(v);
            run_xfer($sformatf("rand%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
